// File: rtl/sound_mixer.sv
// sound_mixer: N-voice sample playback mixer. Each voice walks a region of a
// shared synchronous sample ROM. One mixed sample is produced per codec strobe
// by visiting the voices in turn, summing their samples, then shifting and
// saturating the sum to 16 bits.
module sound_mixer #(
  parameter int N_VOICES = 4,
  parameter int N_SOUNDS = 6,
  parameter int AW       = 15,
  parameter logic [N_SOUNDS-1:0] LOOP_MASK = '0
) (
  input  logic                       aud_mclk,
  input  logic                       reset_n,
  input  logic [N_SOUNDS-1:0]        snd_req,
  input  logic [N_SOUNDS*AW-1:0]     snd_start,
  input  logic [N_SOUNDS*AW-1:0]     snd_end,
  input  logic                       stop_all,
  input  logic [2:0]                 master_shift,
  input  logic                       data_ena,
  output logic [AW-1:0]              rom_addr,
  input  logic signed [7:0]          rom_data,
  output logic signed [15:0]         dac_data_l,
  output logic signed [15:0]         dac_data_r,
  output logic                       sample_valid,
  output logic [N_VOICES-1:0]        voice_active,
  output logic                       overrun
);

  localparam int ACC_W = 16 + $clog2(N_VOICES) + 1;
  localparam int VW    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int SW    = (N_SOUNDS > 1) ? $clog2(N_SOUNDS) : 1;
  localparam int CW    = $clog2(N_VOICES + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SAT} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            k_p0;
  logic [VW-1:0]            fetch_v;
  logic [VW-1:0]            cur_v;
  logic                     fetch_en, acc_en, sat_en, start_en;

  logic [AW-1:0]            addr  [N_VOICES];
  logic [SW-1:0]            sound [N_VOICES];
  logic [N_VOICES-1:0]      active;
  logic [N_SOUNDS-1:0]      pending;

  logic [SW-1:0]            alloc_s;
  logic [VW-1:0]            alloc_v;
  logic                     s_found, v_found, alloc_go;
  logic [N_SOUNDS-1:0]      alloc_clr;

  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [15:0]       dac_p2;
  logic                     vld_p2;

  // Extract the AW-bit address slot for sound s from a packed descriptor bus.
  function automatic logic [AW-1:0] slot(input logic [N_SOUNDS*AW-1:0] bus,
                                         input logic [SW-1:0] s);
    return bus[int'(s)*AW +: AW];
  endfunction

  // A ROM byte lands in the upper half of a 16-bit word, widened to the accumulator.
  function automatic logic signed [ACC_W-1:0] contrib(input logic signed [7:0] d);
    return {{(ACC_W-16){d[7]}}, d, 8'h00};
  endfunction

  // Clamp the shifted mix into the signed 16-bit output range.
  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] x);
    if ((&x[ACC_W-1:15]) || (~|x[ACC_W-1:15]))
      return x[15:0];
    else if (x[ACC_W-1])
      return 16'sh8000;
    else
      return 16'sh7FFF;
  endfunction

  assign fetch_v = VW'(k_p0);
  assign cur_v   = VW'(k_p0 - 1'b1);

  // FSM state register.
  always_ff @(posedge aud_mclk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state: FETCH spans N_VOICES address cycles plus one trailing accumulate.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_ena) state_nxt = FETCH;
      FETCH:   if (k_p0 == CW'(N_VOICES)) state_nxt = SAT;
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: ROM address for voice k, accumulate-enable for voice k-1, saturate.
  always_comb begin
    fetch_en = (state == FETCH) && (k_p0 < CW'(N_VOICES));
    acc_en   = (state == FETCH) && (k_p0 != '0);
    sat_en   = (state == SAT);
    start_en = (state == IDLE) && data_ena;
    rom_addr = fetch_en ? addr[fetch_v] : '0;
  end

  // Voice slot counter, running only while fetching.
  always_ff @(posedge aud_mclk or negedge reset_n) begin
    if (!reset_n)              k_p0 <= '0;
    else if (state == FETCH)   k_p0 <= k_p0 + 1'b1;
    else                       k_p0 <= '0;
  end

  // Pick the lowest pending sound and the lowest free voice; stop_all vetoes allocation.
  always_comb begin
    alloc_s   = '0;
    s_found   = 1'b0;
    alloc_v   = '0;
    v_found   = 1'b0;
    alloc_clr = '0;
    for (int s = 0; s < N_SOUNDS; s++) begin
      if (pending[s] && !s_found) begin
        alloc_s = SW'(s);
        s_found = 1'b1;
      end
    end
    for (int v = 0; v < N_VOICES; v++) begin
      if (!active[v] && !v_found) begin
        alloc_v = VW'(v);
        v_found = 1'b1;
      end
    end
    alloc_go = (state == IDLE) && s_found && v_found && !stop_all;
    if (alloc_go) alloc_clr[alloc_s] = 1'b1;
  end

  // Pending requests: repeated triggers merge; stop_all discards everything incl. this cycle's requests.
  always_ff @(posedge aud_mclk or negedge reset_n) begin
    if (!reset_n)      pending <= '0;
    else if (stop_all) pending <= '0;
    else               pending <= (pending & ~alloc_clr) | snd_req;
  end

  // Per-voice state: allocation load, post-accumulate advance (loop, end or step), kill.
  always_ff @(posedge aud_mclk or negedge reset_n) begin
    if (!reset_n) begin
      active <= '0;
      for (int v = 0; v < N_VOICES; v++) begin
        addr[v]  <= '0;
        sound[v] <= '0;
      end
    end else begin
      for (int v = 0; v < N_VOICES; v++) begin
        if (stop_all) begin
          active[v] <= 1'b0;
        end else if (alloc_go && (alloc_v == VW'(v))) begin
          addr[v]   <= slot(snd_start, alloc_s);
          sound[v]  <= alloc_s;
          active[v] <= 1'b1;
        end else if (acc_en && (cur_v == VW'(v)) && active[v]) begin
          if (addr[v] == slot(snd_end, sound[v])) begin
            if (LOOP_MASK[sound[v]]) addr[v] <= slot(snd_start, sound[v]);
            else                     active[v] <= 1'b0;
          end else begin
            addr[v] <= addr[v] + 1'b1;
          end
        end
      end
    end
  end

  // Stage p1: accumulator, cleared on the strobe, summing one voice per FETCH cycle.
  always_ff @(posedge aud_mclk or negedge reset_n) begin
    if (!reset_n)                      acc_p1 <= '0;
    else if (start_en)                 acc_p1 <= '0;
    else if (acc_en && active[cur_v])  acc_p1 <= acc_p1 + contrib(rom_data);
  end

  // Stage p2: shifted, saturated output with its valid pulse; overrun latches late strobes.
  always_ff @(posedge aud_mclk or negedge reset_n) begin
    if (!reset_n) begin
      dac_p2  <= '0;
      vld_p2  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      vld_p2 <= sat_en;
      if (sat_en) dac_p2 <= sat16(acc_p1 >>> master_shift);
      if (data_ena && (state != IDLE)) overrun <= 1'b1;
    end
  end

  assign dac_data_l   = dac_p2;
  assign dac_data_r   = dac_p2;
  assign sample_valid = vld_p2;
  assign voice_active = active;

endmodule

// File: tb/tb_sound_mixer.sv
// tb_sound_mixer: scoreboard bench for sound_mixer. A frame-level model of the
// voices predicts each mixed sample; a monitor pops predictions as samples appear.
module tb_sound_mixer;
  localparam int NV = 4;
  localparam int NS = 6;
  localparam int AW = 15;
  localparam logic [NS-1:0] LM = 6'b100010;

  logic                   clk;
  logic                   reset_n;
  logic [NS-1:0]          snd_req;
  logic [NS*AW-1:0]       snd_start;
  logic [NS*AW-1:0]       snd_end;
  logic                   stop_all;
  logic [2:0]             master_shift;
  logic                   data_ena;
  logic [AW-1:0]          rom_addr;
  logic signed [7:0]      rom_data;
  logic signed [15:0]     dac_data_l;
  logic signed [15:0]     dac_data_r;
  logic                   sample_valid;
  logic [NV-1:0]          voice_active;
  logic                   overrun;

  logic [7:0] rom [0:(1<<AW)-1];
  int st_a [NS];
  int en_a [NS];

  bit m_act  [NV];
  int m_addr [NV];
  int m_snd  [NV];
  bit m_pend [NS];

  int exp_q [$];
  int n_chk;
  int n_fail;

  sound_mixer #(.N_VOICES(NV), .N_SOUNDS(NS), .AW(AW), .LOOP_MASK(LM)) dut (
    .aud_mclk(clk), .reset_n(reset_n), .snd_req(snd_req),
    .snd_start(snd_start), .snd_end(snd_end), .stop_all(stop_all),
    .master_shift(master_shift), .data_ena(data_ena), .rom_addr(rom_addr),
    .rom_data(rom_data), .dac_data_l(dac_data_l), .dac_data_r(dac_data_r),
    .sample_valid(sample_valid), .voice_active(voice_active), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  always_comb begin
    snd_start = '0;
    snd_end   = '0;
    for (int s = 0; s < NS; s++) begin
      snd_start[s*AW +: AW] = AW'(st_a[s]);
      snd_end[s*AW +: AW]   = AW'(en_a[s]);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Hand pending sounds to free voices, lowest sound to lowest voice.
  function automatic void model_alloc();
    int s, v;
    forever begin
      s = -1;
      v = -1;
      for (int i = NS-1; i >= 0; i--) if (m_pend[i]) s = i;
      for (int i = NV-1; i >= 0; i--) if (!m_act[i]) v = i;
      if (s < 0 || v < 0) break;
      m_pend[s] = 1'b0;
      m_act[v]  = 1'b1;
      m_addr[v] = st_a[s];
      m_snd[v]  = s;
    end
  endfunction

  function automatic void model_clear();
    for (int v = 0; v < NV; v++) m_act[v] = 1'b0;
    for (int s = 0; s < NS; s++) m_pend[s] = 1'b0;
  endfunction

  // One output sample: sum active voices' bytes x256, then step each voice.
  function automatic int model_frame(input int shift);
    int sum, r;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_act[v]) begin
        sum += int'($signed(rom[m_addr[v]])) * 256;
        if (m_addr[v] == en_a[m_snd[v]]) begin
          if (LM[m_snd[v]]) m_addr[v] = st_a[m_snd[v]];
          else              m_act[v]  = 1'b0;
        end else begin
          m_addr[v]++;
        end
      end
    end
    r = sum >>> shift;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic int model_mask();
    int m;
    m = 0;
    for (int v = 0; v < NV; v++) if (m_act[v]) m |= (1 << v);
    return m;
  endfunction

  task automatic pulse_req(input logic [NS-1:0] mask);
    @(negedge clk) snd_req = mask;
    @(negedge clk) snd_req = '0;
    for (int s = 0; s < NS; s++) if (mask[s]) m_pend[s] = 1'b1;
    repeat (NS + 2) @(negedge clk);
    model_alloc();
  endtask

  task automatic do_stop(input logic [NS-1:0] mask);
    @(negedge clk) begin stop_all = 1'b1; snd_req = mask; end
    @(negedge clk) begin stop_all = 1'b0; snd_req = '0; end
    model_clear();
    repeat (2) @(negedge clk);
  endtask

  task automatic frame();
    int a0;
    bit act0;
    model_alloc();
    a0   = m_addr[0];
    act0 = m_act[0];
    exp_q.push_back(model_frame(int'(master_shift)));
    @(negedge clk) data_ena = 1'b1;
    @(negedge clk) data_ena = 1'b0;
    if (act0) chk("rom_addr_voice0", int'(rom_addr), a0);
    repeat (NV + 6) @(negedge clk);
    model_alloc();
  endtask

  task automatic check_active(input string name);
    model_alloc();
    chk(name, int'(voice_active), model_mask());
  endtask

  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_sample: actual %0d required none", int'(dac_data_l));
        end else begin
          e = exp_q.pop_front();
          chk("dac_data_l", int'(dac_data_l), e);
          chk("dac_data_r", int'(dac_data_r), e);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b1;
    snd_req = '0;
    stop_all = 1'b0;
    master_shift = 3'd0;
    data_ena = 1'b0;
    for (int i = 0; i < (1<<AW); i++) rom[i] = 8'($urandom);
    for (int s = 0; s < NS; s++) begin st_a[s] = 0; en_a[s] = 0; end
    model_clear();
    fork
      monitor();
    join_none

    #2 reset_n = 1'b0;
    #20;
    chk("reset_dac", int'(dac_data_l), 0);
    chk("reset_valid", int'(sample_valid), 0);
    chk("reset_active", int'(voice_active), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_rom_addr", int'(rom_addr), 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single non-looping sound, four samples then silence.
    st_a[0] = 0; en_a[0] = 3;
    rom[0] = 8'h10; rom[1] = 8'h20; rom[2] = 8'h30; rom[3] = 8'h40;
    pulse_req(6'b000001);
    check_active("active_after_req0");
    for (int i = 0; i < 5; i++) begin
      frame();
      check_active("active_seq0");
    end

    // Saturation at both rails and with a shift.
    do_stop('0);
    st_a[2] = 100; en_a[2] = 102;
    st_a[3] = 100; en_a[3] = 102;
    rom[100] = 8'h7F; rom[101] = 8'h80; rom[102] = 8'h7F;
    pulse_req(6'b001100);
    master_shift = 3'd0; frame();
    master_shift = 3'd0; frame();
    master_shift = 3'd1; frame();
    master_shift = 3'd0;

    // Five requests onto four voices; the fifth waits for the first free voice.
    do_stop('0);
    for (int s = 0; s < 5; s++) begin
      st_a[s] = 300 + s*16;
      en_a[s] = st_a[s] + s;
    end
    for (int s = 0; s < 5; s++) pulse_req(NS'(1 << s));
    check_active("active_all_busy");
    for (int i = 0; i < 4; i++) begin
      frame();
      check_active("active_after_free");
    end

    // Looping two-sample sound on voice 0.
    do_stop('0);
    st_a[1] = 10; en_a[1] = 11;
    pulse_req(6'b000010);
    for (int i = 0; i < 4; i++) begin
      frame();
      check_active("active_loop");
    end

    // Strobe while busy sets overrun and produces no extra sample.
    chk("overrun_before", int'(overrun), 0);
    model_alloc();
    exp_q.push_back(model_frame(int'(master_shift)));
    @(negedge clk) data_ena = 1'b1;
    @(negedge clk) data_ena = 1'b0;
    @(negedge clk) data_ena = 1'b1;
    @(negedge clk) data_ena = 1'b0;
    repeat (NV + 6) @(negedge clk);
    chk("overrun_set", int'(overrun), 1);

    // stop_all kills the loop; a simultaneous request is discarded.
    do_stop(6'b000001);
    check_active("active_after_stop");
    frame();

    // Asynchronous reset in the middle of FETCH.
    pulse_req(6'b000010);
    @(negedge clk) data_ena = 1'b1;
    @(negedge clk) data_ena = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_dac", int'(dac_data_l), 0);
    chk("midreset_valid", int'(sample_valid), 0);
    chk("midreset_active", int'(voice_active), 0);
    chk("midreset_overrun", int'(overrun), 0);
    chk("midreset_rom_addr", int'(rom_addr), 0);
    model_clear();
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);
    frame();

    // Randomized traffic over short random regions.
    do_stop('0);
    for (int s = 0; s < NS; s++) begin
      st_a[s] = 1000 + s*32 + int'($urandom_range(0, 8));
      en_a[s] = st_a[s] + int'($urandom_range(0, 6));
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) do_stop(NS'($urandom));
      else if ($urandom_range(0, 2) == 0) pulse_req(NS'($urandom));
      master_shift = 3'($urandom_range(0, 3));
      frame();
      if ((i % 5) == 0) check_active("active_random");
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL missing_samples: actual %0d outstanding required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
